// File: rtl/wb_irq_ctrl_pkg.sv
// Shared register map, reset constants and small helpers for the Wishbone
// interrupt controller.
package wb_irq_ctrl_pkg;

    localparam logic [3:0]  PEND_OFS = 4'h0;
    localparam logic [3:0]  EN_OFS   = 4'h4;
    localparam logic [3:0]  MODE_OFS = 4'h8;
    localparam logic [3:0]  RAW_OFS  = 4'hC;

    // All sources come out of reset in rising-edge mode.
    localparam logic [31:0] MODE_RST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        TERM_NONE = 2'd0,
        TERM_ACK  = 2'd1,
        TERM_ERR  = 2'd2
    } term_e;

    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_irq_ctrl_sync.sv
// Per-bit synchronizer chain plus one delay flop for rising-edge detection.
// Edges are masked until the chain has been refilled after reset.
module irq_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_int,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    localparam int              CNT_W     = $clog2(STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(STAGES + 1);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [WIDTH-1:0]             dly_q;
    logic [CNT_W-1:0]             warm_q;
    logic [CNT_W-1:0]             warm_d;
    logic                         warm_done;

    // A source already high at reset release must not look like a fresh edge.
    assign warm_done = (warm_q == WARM_DONE);
    assign warm_d    = warm_done ? warm_q : warm_q + 1'b1;

    always_ff @(posedge clk_int or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            dly_q   <= '0;
            warm_q  <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], src_i};
            dly_q   <= stage_q[STAGES-1];
            warm_q  <= warm_d;
        end
    end

    assign sync_o = stage_q[STAGES-1];
    assign rise_o = stage_q[STAGES-1] & ~dly_q & {WIDTH{warm_done}};

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone classic slave interrupt controller: PEND (W1C), EN, MODE, RAW
// registers with registered interrupt vector and OR-reduced irq line.
module wb_irq_ctrl
    import wb_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_int,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    output logic [NUM_SRC-1:0] irq_vec_o,
    output logic               irq_o
);

    logic [NUM_SRC-1:0] sync_w, rise_w;
    logic [NUM_SRC-1:0] pend_q, pend_d, en_q, en_d, mode_q, mode_d;
    logic [NUM_SRC-1:0] irq_vec_q;
    logic               irq_q, ack_q, err_q;
    logic [31:0]        dat_q, dat_d, rdata;
    logic [31:0]        lane_mask;
    logic [NUM_SRC-1:0] wr_mask, wr_bits, w1c;
    logic [3:0]         acc_ofs;
    logic               acc_start, wr_en;
    term_e              term_d;
    logic               unused_ok;

    irq_sync #(
        .WIDTH  (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk_int (clk_int),
        .rst     (rst),
        .src_i   (src_i),
        .sync_o  (sync_w),
        .rise_o  (rise_w)
    );

    // Handshake: an access is taken when cyc&stb are high and no termination
    // is showing; the single-cycle ack/err follows on the next edge, and the
    // termination itself blocks a new start so it always drops for one cycle.
    assign acc_start = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign wr_en     = acc_start & wb_we_i;
    assign acc_ofs   = {wb_adr_i[3:2], 2'b00};
    assign lane_mask = sel_to_mask(wb_sel_i);
    assign wr_mask   = lane_mask[NUM_SRC-1:0];
    assign wr_bits   = wb_dat_i[NUM_SRC-1:0] & wr_mask;
    assign unused_ok = ^{wb_adr_i, wb_dat_i};

    always_comb begin
        rdata = '0;
        case (acc_ofs)
            PEND_OFS: rdata[NUM_SRC-1:0] = pend_q;
            EN_OFS:   rdata[NUM_SRC-1:0] = en_q;
            MODE_OFS: rdata[NUM_SRC-1:0] = mode_q;
            default:  rdata[NUM_SRC-1:0] = sync_w;
        endcase
    end

    always_comb begin
        w1c    = (wr_en && acc_ofs == PEND_OFS) ? wr_bits : '0;
        en_d   = (wr_en && acc_ofs == EN_OFS) ? ((en_q & ~wr_mask) | wr_bits) : en_q;
        mode_d = (wr_en && acc_ofs == MODE_OFS) ? ((mode_q & ~wr_mask) | wr_bits) : mode_q;
        // Edge bits: a same-cycle rise wins over W1C. Level bits follow the input.
        pend_d = (mode_q & ((pend_q & ~w1c) | rise_w)) | (~mode_q & sync_w);
        if (!acc_start) begin
            term_d = TERM_NONE;
        end else if (wb_we_i && acc_ofs == RAW_OFS) begin
            term_d = TERM_ERR;
        end else begin
            term_d = TERM_ACK;
        end
        dat_d = (acc_start && !wb_we_i) ? rdata : 32'h0;
    end

    always_ff @(posedge clk_int or posedge rst) begin
        if (rst) begin
            pend_q    <= '0;
            en_q      <= '0;
            mode_q    <= MODE_RST[NUM_SRC-1:0];
            irq_vec_q <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            irq_vec_q <= pend_q & en_q;
            irq_q     <= |(pend_q & en_q);
            ack_q     <= (term_d == TERM_ACK);
            err_q     <= (term_d == TERM_ERR);
            dat_q     <= dat_d;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_rty_o  = 1'b0;
    assign irq_vec_o = irq_vec_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Self-checking bench for wb_irq_ctrl: directed scenarios plus random bus and
// source activity, every cycle compared against a history-based reference.
module tb_wb_irq_ctrl;

  localparam int NS = 8;
  localparam int SS = 2;

  // clock / reset / stimulus signals
  logic          clk_int = 1'b0;
  logic          rst     = 1'b1;
  logic [NS-1:0] src     = '0;
  logic [31:0]   adr     = '0;
  logic [31:0]   wdat    = '0;
  logic [3:0]    sel     = '0;
  logic          we      = 1'b0;
  logic          stb     = 1'b0;
  logic          cyc     = 1'b0;

  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_rty_o, irq_o;
  logic [NS-1:0] irq_vec_o;

  always #5 clk_int = ~clk_int;

  wb_irq_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
    .clk_int   (clk_int),
    .rst       (rst),
    .src_i     (src),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_rty_o  (wb_rty_o),
    .irq_vec_o (irq_vec_o),
    .irq_o     (irq_o)
  );

  // scoreboard counters
  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: src history since reset release, register images
  logic [NS-1:0] hist[$];
  logic [NS-1:0] m_pend, m_en, m_mode, m_vec;
  logic          m_irq, m_ack, m_err;
  logic [31:0]   m_dat;

  task automatic model_reset();
    hist.delete();
    m_pend = '0; m_en = '0; m_mode = '1; m_vec = '0;
    m_irq = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_dat = '0;
  endtask

  // One clock edge of behaviour, evaluated from the inputs about to be sampled.
  task automatic model_step();
    int            n;
    logic [NS-1:0] cur, prv, rise, wmask, wbits, w1c, np;
    logic [31:0]   rd;
    logic          start;
    n     = hist.size();
    cur   = (n >= SS) ? hist[n-SS] : '0;
    prv   = (n >= SS + 1) ? hist[n-SS-1] : '0;
    rise  = (n >= SS + 1) ? (cur & ~prv) : '0;
    start = cyc && stb && !m_ack && !m_err;
    for (int i = 0; i < NS; i++) wmask[i] = sel[i/8];
    wbits = wdat[NS-1:0] & wmask;
    rd = '0;
    case (adr[3:2])
      2'd0: rd[NS-1:0] = m_pend;
      2'd1: rd[NS-1:0] = m_en;
      2'd2: rd[NS-1:0] = m_mode;
      default: rd[NS-1:0] = cur;
    endcase
    w1c = (start && we && adr[3:2] == 2'd0) ? wbits : '0;
    for (int i = 0; i < NS; i++) begin
      if (m_mode[i]) np[i] = (m_pend[i] && !w1c[i]) || rise[i];
      else           np[i] = cur[i];
    end
    m_vec = m_pend & m_en;
    m_irq = (m_vec != '0);
    if (start && we && adr[3:2] == 2'd1) m_en   = (m_en & ~wmask) | wbits;
    if (start && we && adr[3:2] == 2'd2) m_mode = (m_mode & ~wmask) | wbits;
    m_pend = np;
    m_err  = start && we && adr[3:2] == 2'd3;
    m_ack  = start && !m_err;
    m_dat  = (start && !we) ? rd : 32'h0;
    hist.push_back(src);
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk_int);
    #1;
    check_val("ack", {31'b0, wb_ack_o}, {31'b0, m_ack});
    check_val("err", {31'b0, wb_err_o}, {31'b0, m_err});
    check_val("rty", {31'b0, wb_rty_o}, 32'h0);
    check_val("dat", wb_dat_o, m_dat);
    check_val("irq_vec", {{(32-NS){1'b0}}, irq_vec_o}, {{(32-NS){1'b0}}, m_vec});
    check_val("irq", {31'b0, irq_o}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_ack", {31'b0, wb_ack_o}, 32'h0);
    check_val("rst_err", {31'b0, wb_err_o}, 32'h0);
    check_val("rst_dat", wb_dat_o, 32'h0);
    check_val("rst_irq", {31'b0, irq_o}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk_int);
    #1;
    rst = 1'b0;
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rdat,
                           output logic got_ack, output logic got_err);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    tick();
    rdat = wb_dat_o; got_ack = wb_ack_o; got_err = wb_err_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic        k, e;
    wb_access(1'b1, a, d, s, r, k, e);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        k, e;
    wb_access(1'b0, a, 32'h0, 4'hF, r, k, e);
    check_val(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic        k, e;
    int          lat;

    model_reset();
    do_reset();
    rd_chk("rst_pend", 32'h0, 32'h00);
    rd_chk("rst_en",   32'h4, 32'h00);
    rd_chk("rst_mode", 32'h8, 32'hFF);
    idle(5);

    // single-cycle edge pulse to irq_o latency
    wr(32'h4, 32'h01, 4'hF);
    src[0] = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      src[0] = 1'b0;
      if (irq_o === 1'b1) break;
    end
    check_val("irq_latency", lat, SS + 2);
    rd_chk("edge_pend", 32'h0, 32'h01);

    // W1C with byte lanes, and a same-cycle edge beating the clear
    wr(32'h0, 32'hFF, 4'hF);
    src = 8'h05; tick(); src = '0; idle(5);
    rd_chk("pend_05", 32'h0, 32'h05);
    wr(32'h0, 32'h04, 4'h1);
    rd_chk("w1c_bit2", 32'h0, 32'h01);
    src[2] = 1'b1; tick(); src[2] = 1'b0;
    idle(SS - 1);
    wr(32'h0, 32'h04, 4'h1);
    rd_chk("w1c_vs_edge", 32'h0, 32'h05);

    // level mode tracks the synchronized input
    wr(32'h8, 32'h00, 4'hF);
    idle(2);
    rd_chk("lvl_clear", 32'h0, 32'h00);
    src[3] = 1'b1; idle(4);
    rd_chk("lvl_high", 32'h0, 32'h08);
    wr(32'h0, 32'h08, 4'hF);
    rd_chk("lvl_w1c", 32'h0, 32'h08);
    src[3] = 1'b0; idle(4);
    rd_chk("lvl_low", 32'h0, 32'h00);

    // write to RAW terminates with err and changes nothing
    wb_access(1'b1, 32'hC, 32'hFF, 4'hF, r, k, e);
    check_val("raw_wr_ack", {31'b0, k}, 32'h0);
    check_val("raw_wr_err", {31'b0, e}, 32'h1);
    rd_chk("raw_en", 32'h4, 32'h01);
    rd_chk("raw_mode", 32'h8, 32'h00);
    wr(32'h8, 32'hFF, 4'hF);

    // byte lanes and bits above NUM_SRC
    wr(32'h4, 32'h0000_00F0, 4'h2);
    rd_chk("lane_off", 32'h4, 32'h01);
    wr(32'h4, 32'hFFFF_FFF3, 4'hF);
    rd_chk("upper_bits", 32'h4, 32'hF3);

    // strobe dropped before any edge samples it
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; wdat = 32'h0; sel = 4'hF;
    #3;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    rd_chk("abort", 32'h4, 32'hF3);

    // source high across reset release, then a real edge
    src[1] = 1'b1;
    do_reset();
    idle(6);
    rd_chk("no_edge_rst", 32'h0, 32'h00);
    src[1] = 1'b0; idle(4);
    src[1] = 1'b1; idle(4);
    rd_chk("edge_after_rst", 32'h0, 32'h02);
    src = '0;

    // reset during a write ack cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; wdat = 32'hAA; sel = 4'hF;
    tick();
    rst = 1'b1;
    #1;
    check_val("mid_rst_ack", {31'b0, wb_ack_o}, 32'h0);
    do_reset();
    rd_chk("mid_rst_en", 32'h4, 32'h00);
    idle(4);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) src[$urandom_range(0, NS-1)] ^= 1'b1;
      if (op < 5) begin
        tick();
      end else if (op < 8) begin
        wb_access(1'b1, {$urandom_range(0, 15), 2'b00} | ($urandom() & 32'hFFFF_FFF0),
                  $urandom(), 4'($urandom_range(0, 15)), r, k, e);
      end else begin
        wb_access(1'b0, {28'h0, 2'($urandom_range(0, 3)), 2'b00}, 32'h0, 4'hF, r, k, e);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb_irq_ctrl.md
WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, number of input synchronizer flops (>=2).
REQ-003 clk_int  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 src_i  input  NUM_SRC  raw interrupt sources, asynchronous to clk_int (debounced buttons, tick, UART received).
REQ-006 wb_adr_i  input  32  Wishbone address; only bits [3:2] decoded.
REQ-007 wb_dat_i  input  32  write data.
REQ-008 wb_sel_i  input  4  byte-lane enables.
REQ-009 wb_we_i, wb_stb_i, wb_cyc_i  input  1 each  Wishbone classic controls.
REQ-010 wb_dat_o  output  32  read data.
REQ-011 wb_ack_o, wb_err_o, wb_rty_o  output  1 each  Wishbone termination.
REQ-012 irq_vec_o  output  NUM_SRC  pending & enable vector feeding cpu interrupt bus.
REQ-013 irq_o  output  1  OR of irq_vec_o.

Function
REQ-014 Each src_i bit SHALL pass through SYNC_STAGES flops, then one delay flop for edge detection.
REQ-015 Register map SHALL be: 0x0 PEND (R/W1C), 0x4 EN (R/W), 0x8 MODE (R/W; 1=rising edge, 0=level), 0xC RAW (R, synchronized src).
REQ-016 Edge mode: pending bit SHALL set on the cycle the synchronized input is first seen 1 after 0; latency src_i rise to irq_o = SYNC_STAGES+2 cycles.
REQ-017 Level mode: pending bit SHALL equal the synchronized input each cycle; W1C has no lasting effect.
REQ-018 Pending SHALL set regardless of EN; EN gates only irq_vec_o.
REQ-019 Simultaneous edge-set and W1C on the same bit SHALL leave the bit set.
REQ-020 irq_vec_o and irq_o SHALL be registered: valid one cycle after PEND/EN change.
REQ-021 Access SHALL start when wb_cyc_i & wb_stb_i & !wb_ack_o; ack or err SHALL pulse exactly one cycle, next cycle, then deassert for at least one cycle.
REQ-022 Writes SHALL apply only to byte lanes with wb_sel_i set; bits at or above NUM_SRC SHALL be ignored on write and read as 0.
REQ-023 wb_err_o SHALL pulse instead of ack for writes to RAW; register state unchanged.
REQ-024 wb_rty_o SHALL be constant 0.
REQ-025 wb_dat_o SHALL hold data during the ack cycle, and be 0 otherwise.
REQ-026 wb_stb_i dropped before ack SHALL abort the access with no termination pulse and no state change.
REQ-027 MODE change edge-to-level SHALL take effect next cycle; level-to-edge SHALL keep the current pending value.

Reset
REQ-028 On rst: sync/delay flops, PEND, EN, irq_vec_o, irq_o, wb_ack_o, wb_err_o, wb_dat_o SHALL be 0; MODE SHALL be all-ones (edge).
REQ-029 Reset asserted mid-access SHALL drop ack/err immediately with no partial register write.
REQ-030 No edge SHALL be detected on the first cycle after reset release when src_i is already high.

Structure
REQ-031 Register offsets (PEND/EN/MODE/RAW) and MODE reset constant SHALL live in the shared defines include.
REQ-032 One sub-module SHALL be used: irq_sync (parameterized synchronizer + edge detector, per-bit vectorized).
REQ-033 Instance SHALL connect as a Wishbone slave of intercon; irq_vec_o SHALL drive the low bits of the cpu interrupt bus.

Verification
REQ-034 EN=0x01, MODE=0xFF, pulse src_i[0] for 1 cycle -> PEND=0x01, irq_o high 4 cycles after the rise.
REQ-035 PEND=0x05, write 0x04 to PEND with sel=0x1 -> PEND=0x01; a same-cycle edge on bit2 -> PEND=0x05.
REQ-036 MODE=0x00, src_i[3] held high then low -> PEND[3] tracks input; W1C read-back still 1 while high.
REQ-037 Write to 0xC -> wb_err_o single pulse, ack 0, registers unchanged; read 0x4 -> ack, EN data.
REQ-038 src_i[1] high across rst deassertion -> no pending bit set; subsequent 0->1 sets PEND[1].
REQ-039 rst asserted during a write ack cycle -> ack 0 at once, EN reads 0x00 after release.
